// File: rtl/div8_seq_if.sv
// Handshake/result bundle for the iterative divider: request side driven by the
// requester (master), results driven by the divider (slave).
interface div8_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div8_seq.sv
// Iterative restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | one trial subtraction per cycle, WIDTH cycles
// FIN   | commit results; done pulses on the following cycle
module div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    div8_seq_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] qreg_q, qreg_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] mag_dvd, mag_dvs;
    logic [WIDTH-1:0] quot_res, rem_res, dz_rem;

    wire accept = (state_q == ST_IDLE) && bus.start;

`ifdef DIV_SIGNED_EN
    logic q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    // Core always sees magnitudes; signs are re-applied when committing.
    assign mag_dvd  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign mag_dvs  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign quot_res = q_neg_q ? -qreg_q : qreg_q;
    assign rem_res  = r_neg_q ? -prem_q : prem_q;
    assign dz_rem   = r_neg_q ? -qreg_q : qreg_q;

    always_comb begin
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        if (accept) begin
            q_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_d = bus.dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end
`else
    assign mag_dvd  = bus.dividend;
    assign mag_dvs  = bus.divisor;
    assign quot_res = qreg_q;
    assign rem_res  = prem_q;
    assign dz_rem   = qreg_q;
`endif

    assign trial = {prem_q, qreg_q[WIDTH-1]} - {1'b0, dvsr_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        qreg_d  = qreg_q;
        dvsr_d  = dvsr_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    prem_d  = '0;
                    qreg_d  = mag_dvd;
                    dvsr_d  = mag_dvs;
                    cnt_d   = CW'(WIDTH);
                    dz_d    = (bus.divisor == '0);
                    state_d = (bus.divisor == '0) ? ST_FIN : ST_CALC;
                end
            end
            ST_CALC: begin
                if (!trial[WIDTH]) begin
                    prem_d = trial[WIDTH-1:0];
                    qreg_d = {qreg_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = {prem_q[WIDTH-2:0], qreg_q[WIDTH-1]};
                    qreg_d = {qreg_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (dz_q) begin
                    quot_d = '1;
                    rem_d  = dz_rem;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = quot_res;
                    rem_d  = rem_res;
                    dbz_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            qreg_q  <= '0;
            dvsr_q  <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            qreg_q  <= qreg_d;
            dvsr_q  <= dvsr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq (WIDTH=8) against an arithmetic reference model.
module tb_div8_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    div8_seq_if #(.WIDTH(W)) bus ();
    div8_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz);
`ifdef DIV_SIGNED_EN
        int sa, sb, qi, ri;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 8'd0) begin
            q = 8'hFF; r = a; dz = 1'b1;
        end else begin
            qi = sa / sb;
            ri = sa % sb;
            q = qi[7:0]; r = ri[7:0]; dz = 1'b0;
        end
`else
        if (b == 8'd0) begin
            q = 8'hFF; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
`endif
    endfunction

    // Drives one request and waits (bounded) for done; lat = -1 on timeout.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_held: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    // Directed corner cases, including divide-by-zero and divisor > dividend.
    task automatic test_directed();
        logic [7:0] ta[8] = '{8'd200, 8'd5, 8'hFF, 8'd3, 8'h80, 8'hFF, 8'd0, 8'd1};
        logic [7:0] tb[8] = '{8'd7, 8'd0, 8'h01, 8'd9, 8'h80, 8'hFF, 8'd0, 8'd255};
        logic [7:0] eq, er;
        logic       ez;
        int         lat, el;
        for (int i = 0; i < 8; i++) begin
            launch(ta[i], tb[i], lat);
            model(ta[i], tb[i], eq, er, ez);
            el = (tb[i] == 8'd0) ? 1 : W + 1;
            n_cmp++;
            if (lat !== el) begin
                n_err++;
                $display("FAIL dir_latency[%0d]: got %0d, want %0d", i, lat, el);
            end
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {eq, er, ez}) begin
                n_err++;
                $display("FAIL dir_result[%0d] %h/%h: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         i, ta[i], tb[i], bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL dir_after[%0d]: got busy=%b done=%b, want 0 0", i, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, eq, er;
        logic       ez;
        int         lat, el;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 8'd0;
                1, 2:    b = 8'($urandom_range(1, 4));
                default: b = 8'($urandom);
            endcase
            launch(a, b, lat);
            model(a, b, eq, er, ez);
            el = (b == 8'd0) ? 1 : W + 1;
            n_cmp++;
            if (lat !== el || {bus.quotient, bus.remainder, bus.div_by_zero} !== {eq, er, ez}) begin
                n_err++;
                $display("FAIL rand[%0d] %h/%h: got lat=%0d q=%h r=%h dz=%b, want lat=%0d q=%h r=%h dz=%b",
                         i, a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero, el, eq, er, ez);
            end
        end
    endtask

    // start during CALC and FIN must be ignored; start in the done cycle is accepted.
    task automatic test_busy_ignore();
        logic [7:0] eq, er;
        logic       ez;
        int         ndone = 0, kdone = -1, lat;
        logic [7:0] gq = '0, gr = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 3 || k == 9) begin
                bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
            end else begin
                bus.start = 1'b0; bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
            end
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                kdone = k;
                gq = bus.quotient;
                gr = bus.remainder;
            end
        end
        bus.start = 1'b0;
        model(8'd100, 8'd10, eq, er, ez);
        n_cmp++;
        if (ndone !== 1 || kdone !== W + 1) begin
            n_err++;
            $display("FAIL busy_ignore_pulses: got %0d pulses (last at %0d), want 1 at %0d",
                     ndone, kdone, W + 1);
        end
        n_cmp++;
        if ({gq, gr} !== {eq, er}) begin
            n_err++;
            $display("FAIL busy_ignore_result: got q=%h r=%h, want q=%h r=%h", gq, gr, eq, er);
        end

        launch(8'd20, 8'd6, lat);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd7; bus.divisor = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        model(8'd7, 8'd3, eq, er, ez);
        n_cmp++;
        if (lat !== W + 1 || {bus.quotient, bus.remainder} !== {eq, er}) begin
            n_err++;
            $display("FAIL back_to_back: got lat=%0d q=%h r=%h, want lat=%0d q=%h r=%h",
                     lat, bus.quotient, bus.remainder, W + 1, eq, er);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] eq, er;
        logic       ez;
        int         ndone = 0, lat;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_err++;
            $display("FAIL reset_abort: got %0d cycles with done/busy after reset, want 0", ndone);
        end
        launch(8'd9, 8'd2, lat);
        model(8'd9, 8'd2, eq, er, ez);
        n_cmp++;
        if (lat !== W + 1 || {bus.quotient, bus.remainder, bus.div_by_zero} !== {eq, er, ez}) begin
            n_err++;
            $display("FAIL after_reset: got lat=%0d q=%h r=%h dz=%b, want lat=%0d q=%h r=%h dz=%b",
                     lat, bus.quotient, bus.remainder, bus.div_by_zero, W + 1, eq, er, ez);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        logic [7:0] ta[4] = '{8'hF9, 8'h07, 8'h80, 8'hFB};
        logic [7:0] tb[4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
        logic [7:0] xq[4] = '{8'hFD, 8'hFD, 8'h80, 8'hFF};
        logic [7:0] xr[4] = '{8'hFF, 8'h01, 8'h00, 8'hFB};
        logic       xz[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int         lat;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i], lat);
            n_cmp++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {xq[i], xr[i], xz[i]}) begin
                n_err++;
                $display("FAIL signed[%0d] %h/%h: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         i, ta[i], tb[i], bus.quotient, bus.remainder, bus.div_by_zero,
                         xq[i], xr[i], xz[i]);
            end
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_mid();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
